decode_execute_unit: RTL and testbench

- RV32I decode-plus-execute slice: combinational control unit decoding the instruction in the decode stage.
- One ID/EX pipeline register holds decoded controls and operands.
- The execute-stage ALU and branch unit compute from the registered values.
- Sits between the register unit / immediate unit (upstream) and the EX/MEM register (downstream); drives the fetch next-PC select.

---
 rtl/rv32_pkg.sv | 67 ++++++
 rtl/rv32_alu.sv | 35 +++
 rtl/rv32_branch_cmp.sv | 33 +++
 rtl/decode_execute_unit.sv | 194 +++++++++++++++++++
 tb/tb_decode_execute_unit.sv | 212 +++++++++++++++++++++
 5 files changed

// File: rtl/rv32_pkg.sv
// Shared RV32I decode/execute types: opcodes, ALU/branch op codes,
// immediate formats, writeback sources and the ID/EX control bundle.
package rv32_pkg;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  typedef enum logic [3:0] {
    ALU_ADD   = 4'b0000,
    ALU_SLL   = 4'b0001,
    ALU_SLT   = 4'b0010,
    ALU_SLTU  = 4'b0011,
    ALU_XOR   = 4'b0100,
    ALU_SRL   = 4'b0101,
    ALU_OR    = 4'b0110,
    ALU_AND   = 4'b0111,
    ALU_SUB   = 4'b1000,
    ALU_SRA   = 4'b1101,
    ALU_PASSB = 4'b1111
  } alu_op_e;

  localparam logic [4:0] BR_NONE = 5'b00000;
  localparam logic [4:0] BR_JUMP = 5'b01000;
  localparam logic [1:0] BR_COND = 2'b10;

  typedef enum logic [2:0] {
    IMM_I = 3'b000,
    IMM_S = 3'b001,
    IMM_B = 3'b010,
    IMM_U = 3'b011,
    IMM_J = 3'b100
  } imm_src_e;

  typedef enum logic [1:0] {
    WB_ALU = 2'b00,
    WB_MEM = 2'b01,
    WB_PC4 = 2'b10
  } wb_src_e;

  typedef struct packed {
    logic       ru_wr;
    logic       dm_wr;
    logic       a_src;
    logic       b_src;
    logic       jalr;
    alu_op_e    alu_op;
    logic [4:0] br_op;
    logic [2:0] dm_ctrl;
    wb_src_e    wb_src;
    logic       illegal;
  } ctrl_t;

  // All-zero control word: no writes, no redirect, ADD of the operands.
  function automatic ctrl_t ctrl_bubble();
    ctrl_t c;
    c = '0;
    return c;
  endfunction

endpackage

// File: rtl/rv32_alu.sv
// Pure combinational RV32I ALU; unlisted op codes produce zero.
module rv32_alu
  import rv32_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] a_i,
  input  logic [XLEN-1:0] b_i,
  input  alu_op_e         op_i,
  output logic [XLEN-1:0] res_o
);

  logic [4:0] shamt_s;
  assign shamt_s = b_i[4:0];

  // Operation select.
  always_comb begin
    res_o = '0;
    case (op_i)
      ALU_ADD:   res_o = a_i + b_i;
      ALU_SUB:   res_o = a_i - b_i;
      ALU_SLL:   res_o = a_i << shamt_s;
      ALU_SLT:   res_o = {{(XLEN-1){1'b0}}, ($signed(a_i) < $signed(b_i))};
      ALU_SLTU:  res_o = {{(XLEN-1){1'b0}}, (a_i < b_i)};
      ALU_XOR:   res_o = a_i ^ b_i;
      ALU_SRL:   res_o = a_i >> shamt_s;
      ALU_SRA:   res_o = $unsigned($signed(a_i) >>> shamt_s);
      ALU_OR:    res_o = a_i | b_i;
      ALU_AND:   res_o = a_i & b_i;
      ALU_PASSB: res_o = b_i;
      default:   res_o = '0;
    endcase
  end

endmodule

// File: rtl/rv32_branch_cmp.sv
// Branch decision from the raw register operands and the registered BrOp.
module rv32_branch_cmp
  import rv32_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] rs1_i,
  input  logic [XLEN-1:0] rs2_i,
  input  logic [4:0]      br_op_i,
  output logic            taken_o
);

  // Conditional codes 010/011 fall through to not-taken.
  always_comb begin
    taken_o = 1'b0;
    if (br_op_i[4]) begin
      case (br_op_i[2:0])
        3'b000:  taken_o = (rs1_i == rs2_i);
        3'b001:  taken_o = (rs1_i != rs2_i);
        3'b100:  taken_o = ($signed(rs1_i) <  $signed(rs2_i));
        3'b101:  taken_o = ($signed(rs1_i) >= $signed(rs2_i));
        3'b110:  taken_o = (rs1_i <  rs2_i);
        3'b111:  taken_o = (rs1_i >= rs2_i);
        default: taken_o = 1'b0;
      endcase
    end else if (br_op_i[3]) begin
      taken_o = 1'b1;
    end else begin
      taken_o = 1'b0;
    end
  end

endmodule

// File: rtl/decode_execute_unit.sv
// RV32I decode + ID/EX register + execute slice: inline control decode,
// one pipeline register, then ALU and branch compare on registered values.
module decode_execute_unit
  import rv32_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            id_valid,
  input  logic            id_flush,
  input  logic [31:0]     id_inst,
  input  logic [XLEN-1:0] id_pc,
  input  logic [XLEN-1:0] id_rs1_val,
  input  logic [XLEN-1:0] id_rs2_val,
  input  logic [XLEN-1:0] id_imm_ext,
  output logic [2:0]      id_imm_src,
  output logic [XLEN-1:0] ex_alu_res,
  output logic            ex_next_pc_src,
  output logic [XLEN-1:0] ex_rs2_val,
  output logic [XLEN-1:0] ex_pc_inc,
  output logic [4:0]      ex_rd,
  output logic            ex_ru_wr,
  output logic            ex_dm_wr,
  output logic [2:0]      ex_dm_ctrl,
  output logic [1:0]      ex_ru_data_wr_src,
  output logic            ex_illegal
);

  function automatic ctrl_t decode_ctrl(input logic [31:0] inst);
    ctrl_t      c;
    logic [2:0] f3;
    logic       f7b5;
    c    = ctrl_bubble();
    f3   = inst[14:12];
    f7b5 = inst[30];
    case (inst[6:0])
      OP_R: begin
        c.ru_wr  = 1'b1;
        c.alu_op = alu_op_e'({f7b5, f3});
      end
      OP_IMM: begin
        c.ru_wr  = 1'b1;
        c.b_src  = 1'b1;
        // Bit 30 is immediate data except for the SRLI/SRAI split.
        c.alu_op = (f3 == 3'b101) ? alu_op_e'({f7b5, f3}) : alu_op_e'({1'b0, f3});
      end
      OP_LOAD: begin
        c.ru_wr   = 1'b1;
        c.b_src   = 1'b1;
        c.dm_ctrl = f3;
        c.wb_src  = WB_MEM;
      end
      OP_STORE: begin
        c.dm_wr   = 1'b1;
        c.b_src   = 1'b1;
        c.dm_ctrl = f3;
      end
      OP_BRANCH: begin
        c.a_src = 1'b1;
        c.b_src = 1'b1;
        c.br_op = {BR_COND, f3};
      end
      OP_JAL: begin
        c.ru_wr  = 1'b1;
        c.a_src  = 1'b1;
        c.b_src  = 1'b1;
        c.br_op  = BR_JUMP;
        c.wb_src = WB_PC4;
      end
      OP_JALR: begin
        c.ru_wr  = 1'b1;
        c.b_src  = 1'b1;
        c.jalr   = 1'b1;
        c.br_op  = BR_JUMP;
        c.wb_src = WB_PC4;
      end
      OP_LUI: begin
        c.ru_wr  = 1'b1;
        c.b_src  = 1'b1;
        c.alu_op = ALU_PASSB;
      end
      OP_AUIPC: begin
        c.ru_wr = 1'b1;
        c.a_src = 1'b1;
        c.b_src = 1'b1;
      end
      default: begin
        c.illegal = 1'b1;
      end
    endcase
    return c;
  endfunction

  function automatic imm_src_e decode_imm_src(input logic [6:0] opcode);
    imm_src_e s;
    case (opcode)
      OP_STORE:         s = IMM_S;
      OP_BRANCH:        s = IMM_B;
      OP_LUI, OP_AUIPC: s = IMM_U;
      OP_JAL:           s = IMM_J;
      default:          s = IMM_I;
    endcase
    return s;
  endfunction

  ctrl_t           id_ctrl_s;
  ctrl_t           ctrl_d, ctrl_q;
  logic [XLEN-1:0] pc_d, pc_q;
  logic [XLEN-1:0] rs1_d, rs1_q;
  logic [XLEN-1:0] rs2_d, rs2_q;
  logic [XLEN-1:0] imm_d, imm_q;
  logic [XLEN-1:0] pc_inc_d, pc_inc_q;
  logic [4:0]      rd_d, rd_q;
  logic            unused_inst_s;

  assign id_ctrl_s     = decode_ctrl(id_inst);
  assign id_imm_src    = decode_imm_src(id_inst[6:0]);
  assign unused_inst_s = ^{id_inst[31], id_inst[29:15]};

  // Next ID/EX contents; flush dominates valid.
  always_comb begin
    ctrl_d   = ctrl_bubble();
    pc_d     = '0;
    rs1_d    = '0;
    rs2_d    = '0;
    imm_d    = '0;
    pc_inc_d = '0;
    rd_d     = 5'd0;
    if (id_flush || !id_valid) begin
      ctrl_d = ctrl_bubble();
    end else begin
      ctrl_d   = id_ctrl_s;
      pc_d     = id_pc;
      rs1_d    = id_rs1_val;
      rs2_d    = id_rs2_val;
      imm_d    = id_imm_ext;
      pc_inc_d = id_pc + {{(XLEN-3){1'b0}}, 3'd4};
      rd_d     = id_inst[11:7];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctrl_q   <= ctrl_bubble();
      pc_q     <= '0;
      rs1_q    <= '0;
      rs2_q    <= '0;
      imm_q    <= '0;
      pc_inc_q <= '0;
      rd_q     <= 5'd0;
    end else begin
      ctrl_q   <= ctrl_d;
      pc_q     <= pc_d;
      rs1_q    <= rs1_d;
      rs2_q    <= rs2_d;
      imm_q    <= imm_d;
      pc_inc_q <= pc_inc_d;
      rd_q     <= rd_d;
    end
  end

  logic [XLEN-1:0] alu_a_s, alu_b_s, alu_res_s;
  logic            taken_s;

  assign alu_a_s = ctrl_q.a_src ? pc_q  : rs1_q;
  assign alu_b_s = ctrl_q.b_src ? imm_q : rs2_q;

  rv32_alu #(.XLEN(XLEN)) u_alu (
    .a_i   (alu_a_s),
    .b_i   (alu_b_s),
    .op_i  (ctrl_q.alu_op),
    .res_o (alu_res_s)
  );

  rv32_branch_cmp #(.XLEN(XLEN)) u_branch_cmp (
    .rs1_i   (rs1_q),
    .rs2_i   (rs2_q),
    .br_op_i (ctrl_q.br_op),
    .taken_o (taken_s)
  );

  assign ex_alu_res        = ctrl_q.jalr ? {alu_res_s[XLEN-1:1], 1'b0} : alu_res_s;
  assign ex_next_pc_src    = taken_s;
  assign ex_rs2_val        = rs2_q;
  assign ex_pc_inc         = pc_inc_q;
  assign ex_rd             = rd_q;
  assign ex_ru_wr          = ctrl_q.ru_wr;
  assign ex_dm_wr          = ctrl_q.dm_wr;
  assign ex_dm_ctrl        = ctrl_q.dm_ctrl;
  assign ex_ru_data_wr_src = ctrl_q.wb_src;
  assign ex_illegal        = ctrl_q.illegal;

endmodule

// File: tb/tb_decode_execute_unit.sv
// Scoreboard bench for decode_execute_unit: expectations are queued when an
// instruction is driven and compared one cycle later.
module tb_decode_execute_unit;

  logic        clk;
  logic        rst_n;
  logic        id_valid;
  logic        id_flush;
  logic [31:0] id_inst;
  logic [31:0] id_pc;
  logic [31:0] id_rs1_val;
  logic [31:0] id_rs2_val;
  logic [31:0] id_imm_ext;
  logic [2:0]  id_imm_src;
  logic [31:0] ex_alu_res;
  logic        ex_next_pc_src;
  logic [31:0] ex_rs2_val;
  logic [31:0] ex_pc_inc;
  logic [4:0]  ex_rd;
  logic        ex_ru_wr;
  logic        ex_dm_wr;
  logic [2:0]  ex_dm_ctrl;
  logic [1:0]  ex_ru_data_wr_src;
  logic        ex_illegal;

  decode_execute_unit dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .id_valid          (id_valid),
    .id_flush          (id_flush),
    .id_inst           (id_inst),
    .id_pc             (id_pc),
    .id_rs1_val        (id_rs1_val),
    .id_rs2_val        (id_rs2_val),
    .id_imm_ext        (id_imm_ext),
    .id_imm_src        (id_imm_src),
    .ex_alu_res        (ex_alu_res),
    .ex_next_pc_src    (ex_next_pc_src),
    .ex_rs2_val        (ex_rs2_val),
    .ex_pc_inc         (ex_pc_inc),
    .ex_rd             (ex_rd),
    .ex_ru_wr          (ex_ru_wr),
    .ex_dm_wr          (ex_dm_wr),
    .ex_dm_ctrl        (ex_dm_ctrl),
    .ex_ru_data_wr_src (ex_ru_data_wr_src),
    .ex_illegal        (ex_illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] alu;
    logic        npc;
    logic [31:0] rs2;
    logic [31:0] pcinc;
    logic [4:0]  rd;
    logic        ru_wr;
    logic        dm_wr;
    logic [2:0]  dmc;
    logic [1:0]  wb;
    logic        ill;
  } exp_t;

  exp_t  exp_q[$];
  string tag_q[$];
  int    n_checks = 0;
  int    n_errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic exp_t mk(input logic [31:0] alu, input logic npc, input logic [31:0] rs2,
                              input logic [31:0] pcinc, input logic [4:0] rd, input logic ru_wr,
                              input logic dm_wr, input logic [2:0] dmc, input logic [1:0] wb,
                              input logic ill);
    exp_t e;
    e.alu = alu; e.npc = npc; e.rs2 = rs2; e.pcinc = pcinc; e.rd = rd;
    e.ru_wr = ru_wr; e.dm_wr = dm_wr; e.dmc = dmc; e.wb = wb; e.ill = ill;
    return e;
  endfunction

  function automatic logic [31:0] mk_inst(input logic [6:0] op, input logic [2:0] f3,
                                          input logic f7b5, input logic [4:0] rd);
    return {1'b0, f7b5, 5'd0, 5'd0, 5'd0, f3, rd, op};
  endfunction

  task automatic issue(input string tag, input logic [31:0] inst, input logic [31:0] pc,
                       input logic [31:0] rs1, input logic [31:0] rs2, input logic [31:0] imm,
                       input logic valid, input logic flush, input logic chk_imm,
                       input logic [2:0] exp_imm, input exp_t e);
    @(posedge clk);
    #2;
    id_inst = inst; id_pc = pc; id_rs1_val = rs1; id_rs2_val = rs2; id_imm_ext = imm;
    id_valid = valid; id_flush = flush;
    #1;
    if (chk_imm) chk({tag, ".imm_src"}, {29'd0, id_imm_src}, {29'd0, exp_imm});
    exp_q.push_back(e);
    tag_q.push_back(tag);
  endtask

  // Scoreboard: compare the oldest expectation one step after each capture edge.
  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) begin
      exp_t  e;
      string t;
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      chk({t, ".alu"},   ex_alu_res, e.alu);
      chk({t, ".npc"},   {31'd0, ex_next_pc_src}, {31'd0, e.npc});
      chk({t, ".rs2"},   ex_rs2_val, e.rs2);
      chk({t, ".pcinc"}, ex_pc_inc, e.pcinc);
      chk({t, ".rd"},    {27'd0, ex_rd}, {27'd0, e.rd});
      chk({t, ".ru_wr"}, {31'd0, ex_ru_wr}, {31'd0, e.ru_wr});
      chk({t, ".dm_wr"}, {31'd0, ex_dm_wr}, {31'd0, e.dm_wr});
      chk({t, ".dmc"},   {29'd0, ex_dm_ctrl}, {29'd0, e.dmc});
      chk({t, ".wb"},    {30'd0, ex_ru_data_wr_src}, {30'd0, e.wb});
      chk({t, ".ill"},   {31'd0, ex_illegal}, {31'd0, e.ill});
    end
  end

  task automatic drain(input string tag);
    for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(posedge clk);
    #2;
    chk({tag, ".drain"}, exp_q.size(), 32'd0);
  endtask

  exp_t zero_e;

  initial begin
    rst_n = 1'b0; id_valid = 1'b0; id_flush = 1'b0; id_inst = 32'd0;
    id_pc = 32'd0; id_rs1_val = 32'd0; id_rs2_val = 32'd0; id_imm_ext = 32'd0;
    zero_e = mk(32'd0, 1'b0, 32'd0, 32'd0, 5'd0, 1'b0, 1'b0, 3'd0, 2'd0, 1'b0);
    #12;
    chk("rst.alu", ex_alu_res, 32'd0);
    chk("rst.npc", {31'd0, ex_next_pc_src}, 32'd0);
    chk("rst.ru_wr", {31'd0, ex_ru_wr}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    issue("sub",  mk_inst(7'b0110011, 3'b000, 1'b1, 5'd5), 32'h10, 32'd3, 32'd5, 32'd0, 1'b1, 1'b0, 1'b0, 3'd0,
          mk(32'hFFFFFFFE, 1'b0, 32'd5, 32'h14, 5'd5, 1'b1, 1'b0, 3'd0, 2'd0, 1'b0));
    issue("sra",  mk_inst(7'b0110011, 3'b101, 1'b1, 5'd6), 32'h14, 32'h80000000, 32'd4, 32'd0, 1'b1, 1'b0, 1'b0, 3'd0,
          mk(32'hF8000000, 1'b0, 32'd4, 32'h18, 5'd6, 1'b1, 1'b0, 3'd0, 2'd0, 1'b0));
    issue("sltu", mk_inst(7'b0110011, 3'b011, 1'b0, 5'd7), 32'h18, 32'd1, 32'hFFFFFFFF, 32'd0, 1'b1, 1'b0, 1'b0, 3'd0,
          mk(32'd1, 1'b0, 32'hFFFFFFFF, 32'h1C, 5'd7, 1'b1, 1'b0, 3'd0, 2'd0, 1'b0));
    issue("slt",  mk_inst(7'b0110011, 3'b010, 1'b0, 5'd7), 32'h1C, 32'd1, 32'hFFFFFFFF, 32'd0, 1'b1, 1'b0, 1'b0, 3'd0,
          mk(32'd0, 1'b0, 32'hFFFFFFFF, 32'h20, 5'd7, 1'b1, 1'b0, 3'd0, 2'd0, 1'b0));
    issue("and",  mk_inst(7'b0110011, 3'b111, 1'b0, 5'd2), 32'h20, 32'h0000F0F0, 32'h0000FF00, 32'd0, 1'b1, 1'b0, 1'b0, 3'd0,
          mk(32'h0000F000, 1'b0, 32'h0000FF00, 32'h24, 5'd2, 1'b1, 1'b0, 3'd0, 2'd0, 1'b0));
    issue("srai", mk_inst(7'b0010011, 3'b101, 1'b1, 5'd8), 32'h24, 32'h80000000, 32'd0, 32'h00000404, 1'b1, 1'b0, 1'b1, 3'b000,
          mk(32'hF8000000, 1'b0, 32'd0, 32'h28, 5'd8, 1'b1, 1'b0, 3'd0, 2'd0, 1'b0));
    issue("addi", mk_inst(7'b0010011, 3'b000, 1'b1, 5'd9), 32'h28, 32'd10, 32'd0, 32'h40000003, 1'b1, 1'b0, 1'b1, 3'b000,
          mk(32'h4000000D, 1'b0, 32'd0, 32'h2C, 5'd9, 1'b1, 1'b0, 3'd0, 2'd0, 1'b0));
    issue("beq",  mk_inst(7'b1100011, 3'b000, 1'b0, 5'd0), 32'h100, 32'd7, 32'd7, 32'h10, 1'b1, 1'b0, 1'b1, 3'b010,
          mk(32'h110, 1'b1, 32'd7, 32'h104, 5'd0, 1'b0, 1'b0, 3'd0, 2'd0, 1'b0));
    issue("bne",  mk_inst(7'b1100011, 3'b001, 1'b0, 5'd0), 32'h100, 32'd7, 32'd7, 32'h10, 1'b1, 1'b0, 1'b1, 3'b010,
          mk(32'h110, 1'b0, 32'd7, 32'h104, 5'd0, 1'b0, 1'b0, 3'd0, 2'd0, 1'b0));
    issue("blt",  mk_inst(7'b1100011, 3'b100, 1'b0, 5'd0), 32'h120, 32'hFFFFFFFF, 32'd1, 32'hFFFFFFF0, 1'b1, 1'b0, 1'b1, 3'b010,
          mk(32'h110, 1'b1, 32'd1, 32'h124, 5'd0, 1'b0, 1'b0, 3'd0, 2'd0, 1'b0));
    issue("bgeu", mk_inst(7'b1100011, 3'b111, 1'b0, 5'd0), 32'h140, 32'hFFFFFFFF, 32'd1, 32'h20, 1'b1, 1'b0, 1'b1, 3'b010,
          mk(32'h160, 1'b1, 32'd1, 32'h144, 5'd0, 1'b0, 1'b0, 3'd0, 2'd0, 1'b0));
    issue("jal",  mk_inst(7'b1101111, 3'b000, 1'b0, 5'd1), 32'h400, 32'd0, 32'd0, 32'h20, 1'b1, 1'b0, 1'b1, 3'b100,
          mk(32'h420, 1'b1, 32'd0, 32'h404, 5'd1, 1'b1, 1'b0, 3'd0, 2'b10, 1'b0));
    issue("jalr", mk_inst(7'b1100111, 3'b000, 1'b0, 5'd1), 32'h200, 32'h1001, 32'd0, 32'd4, 1'b1, 1'b0, 1'b1, 3'b000,
          mk(32'h1004, 1'b1, 32'd0, 32'h204, 5'd1, 1'b1, 1'b0, 3'd0, 2'b10, 1'b0));
    issue("lw",   mk_inst(7'b0000011, 3'b010, 1'b0, 5'd7), 32'h300, 32'h1000, 32'd0, 32'd8, 1'b1, 1'b0, 1'b1, 3'b000,
          mk(32'h1008, 1'b0, 32'd0, 32'h304, 5'd7, 1'b1, 1'b0, 3'b010, 2'b01, 1'b0));
    issue("sw",   mk_inst(7'b0100011, 3'b010, 1'b0, 5'd0), 32'h304, 32'h1000, 32'hDEADBEEF, 32'hC, 1'b1, 1'b0, 1'b1, 3'b001,
          mk(32'h100C, 1'b0, 32'hDEADBEEF, 32'h308, 5'd0, 1'b0, 1'b1, 3'b010, 2'b00, 1'b0));
    issue("lui",  mk_inst(7'b0110111, 3'b000, 1'b0, 5'd3), 32'h308, 32'h55, 32'd0, 32'h12345000, 1'b1, 1'b0, 1'b1, 3'b011,
          mk(32'h12345000, 1'b0, 32'd0, 32'h30C, 5'd3, 1'b1, 1'b0, 3'd0, 2'd0, 1'b0));
    issue("auipc", mk_inst(7'b0010111, 3'b000, 1'b0, 5'd4), 32'h1000, 32'd0, 32'd0, 32'h2000, 1'b1, 1'b0, 1'b1, 3'b011,
          mk(32'h3000, 1'b0, 32'd0, 32'h1004, 5'd4, 1'b1, 1'b0, 3'd0, 2'd0, 1'b0));
    issue("flush", mk_inst(7'b0110011, 3'b000, 1'b0, 5'd5), 32'h500, 32'd1, 32'd2, 32'd0, 1'b1, 1'b1, 1'b0, 3'd0, zero_e);
    issue("inval", mk_inst(7'b0110011, 3'b000, 1'b0, 5'd5), 32'h500, 32'd1, 32'd2, 32'd0, 1'b0, 1'b0, 1'b0, 3'd0, zero_e);
    issue("illeg", mk_inst(7'b1111111, 3'b000, 1'b0, 5'd0), 32'h600, 32'd0, 32'd0, 32'd0, 1'b1, 1'b0, 1'b0, 3'd0,
          mk(32'd0, 1'b0, 32'd0, 32'h604, 5'd0, 1'b0, 1'b0, 3'd0, 2'd0, 1'b1));
    issue("post_ill", 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 3'd0, zero_e);
    issue("jal2", mk_inst(7'b1101111, 3'b000, 1'b0, 5'd1), 32'h800, 32'd0, 32'd0, 32'h40, 1'b1, 1'b0, 1'b1, 3'b100,
          mk(32'h840, 1'b1, 32'd0, 32'h804, 5'd1, 1'b1, 1'b0, 3'd0, 2'b10, 1'b0));
    drain("main");

    // Asynchronous reset mid-cycle while a jump sits in ID/EX.
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("arst.alu",   ex_alu_res, 32'd0);
    chk("arst.npc",   {31'd0, ex_next_pc_src}, 32'd0);
    chk("arst.pcinc", ex_pc_inc, 32'd0);
    chk("arst.rd",    {27'd0, ex_rd}, 32'd0);
    chk("arst.ru_wr", {31'd0, ex_ru_wr}, 32'd0);
    chk("arst.wb",    {30'd0, ex_ru_data_wr_src}, 32'd0);
    @(negedge clk);
    id_valid = 1'b0;
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("idle.ru_wr", {31'd0, ex_ru_wr}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
